// File: rtl/status_uart_tx_if.sv
// Status byte / UART TX port bundle.
//   data_in     status byte from the LED driver (driven by master)
//   tx          UART serial line, idle high
//   busy        high while a message is being sent
//   frame_done  one-cycle pulse after the last stop bit of a message
//   overrun     one-cycle pulse when an unsent pending value is replaced
// master = producer of data_in / observer of the line, slave = status_uart_tx.
interface status_uart_tx_if;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (output data_in, input tx, busy, frame_done, overrun);
  modport slave  (input data_in, output tx, busy, frame_done, overrun);
endinterface

// File: rtl/status_uart_tx.sv
// status_uart_tx: watches the LED driver's status byte and, on every change,
// transmits the new value as two uppercase hex characters (optionally followed
// by CR LF) on a UART 8N1 line. One value can wait in a pending register while
// a message is in flight; replacing an unsent pending value pulses overrun.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    status_uart_tx_if.slave: data_in in; tx, busy, frame_done, overrun out
module status_uart_tx #(
  parameter int CLK_HZ       = 49152000,
  parameter int BAUD         = 9600,
  parameter int SEND_NEWLINE = 1
) (
  input  logic clk,
  input  logic reset,
  status_uart_tx_if.slave bus
);

  localparam int                BAUD_DIV  = CLK_HZ / BAUD;
  localparam int                CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BAUD_DIV - 1);
  localparam logic [1:0]        LAST_CHAR = (SEND_NEWLINE != 0) ? 2'd3 : 2'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       char_q, char_d;
  logic [7:0]       data_q;
  logic [7:0]       msg_q, msg_d;
  logic [7:0]       pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             tx_q, tx_d;
  logic             busy_q;
  logic             fd_q, fd_d;
  logic             ov_q, ov_d;
  logic             change, tick, msg_end;
  logic [7:0]       cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] msg_char(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return hex_ascii(b[7:4]);
      2'd1:    return hex_ascii(b[3:0]);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign change  = (bus.data_in != data_q);
  assign tick    = (cnt_q == CNT_MAX);
  assign msg_end = (state_q == STOP) && tick && (char_q == LAST_CHAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    char_d     = char_q;
    msg_d      = msg_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    fd_d       = 1'b0;
    ov_d       = 1'b0;
    tx_d       = 1'b1;
    cur_char   = 8'h00;

    if (state_q != IDLE)
      cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (change) begin
          state_d = START;
          cnt_d   = '0;
          char_d  = 2'd0;
          bit_d   = 3'd0;
          msg_d   = bus.data_in;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP: if (tick && (char_q != LAST_CHAR)) begin
        state_d = START;
        char_d  = char_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase

    // A change landing on the final stop-bit cycle supersedes any pending
    // value and is sent next without flagging an overrun.
    if (msg_end) begin
      fd_d   = 1'b1;
      pend_d = 1'b0;
      if (change || pend_q) begin
        state_d = START;
        cnt_d   = '0;
        char_d  = 2'd0;
        bit_d   = 3'd0;
        msg_d   = change ? bus.data_in : pend_val_q;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q != IDLE) && change) begin
      pend_d     = 1'b1;
      pend_val_d = bus.data_in;
      ov_d       = pend_q;
    end

    // Line level is derived from the next state so tx can be a plain flop.
    cur_char = msg_char(msg_d, char_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_char[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      char_q  <= 2'd0;
      pend_q  <= 1'b0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      pend_q  <= pend_d;
      data_q  <= bus.data_in;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      fd_q    <= fd_d;
      ov_q    <= ov_d;
    end
  end

  // Payload registers carry no reset: they are only read once qualified by
  // state/pending flags that reset does clear.
  always_ff @(posedge clk) begin
    msg_q      <= msg_d;
    pend_val_q <= pend_val_d;
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
  assign bus.overrun    = ov_q;

endmodule

// File: tb/tb_status_uart_tx.sv
// Bench for status_uart_tx: two instances (with and without CR LF) share one
// stimulus byte. A timing model predicts the line and flags every cycle; a
// mid-bit UART receiver collects characters for literal message checks.
module tb_status_uart_tx;

  localparam int CLK_HZ = 49152000;
  localparam int DIV    = 16;
  localparam int CHAR_T = 10 * DIV;

  logic       clk;
  logic       reset;
  logic [7:0] din;

  status_uart_tx_if bus_nl ();
  status_uart_tx_if bus_nn ();
  assign bus_nl.data_in = din;
  assign bus_nn.data_in = din;

  status_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(CLK_HZ / DIV), .SEND_NEWLINE(1)) dut_nl (
    .clk(clk), .reset(reset), .bus(bus_nl));
  status_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(CLK_HZ / DIV), .SEND_NEWLINE(0)) dut_nn (
    .clk(clk), .reset(reset), .bus(bus_nn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs(input int i);
    if (i == 0) return {bus_nl.tx, bus_nl.busy, bus_nl.frame_done, bus_nl.overrun};
    return {bus_nn.tx, bus_nn.busy, bus_nn.frame_done, bus_nn.overrun};
  endfunction

  function automatic logic line(input int i);
    return (i == 0) ? bus_nl.tx : bus_nn.tx;
  endfunction

  // ---------------- behavioural model ----------------
  int         mcyc = 0;
  int         m_len [2] = '{4, 2};
  bit         m_act [2];
  int         m_start [2];
  logic [7:0] m_msg [2];
  bit         m_pend [2];
  logic [7:0] m_pval [2];
  logic [7:0] m_q [2];
  bit         m_fd [2];
  bit         m_ov [2];

  function automatic logic [7:0] exp_char(input logic [7:0] b, input int c);
    string hx = "0123456789ABCDEF";
    case (c)
      0:       return hx.getc(int'(b[7:4]));
      1:       return hx.getc(int'(b[3:0]));
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic exp_tx(input int i);
    int t, c, b;
    logic [7:0] ch;
    if (!m_act[i]) return 1'b1;
    t = mcyc - m_start[i];
    c = t / CHAR_T;
    b = (t % CHAR_T) / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    ch = exp_char(m_msg[i], c);
    return ch[b-1];
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_pend[i] = 0; m_q[i] = 8'h00; m_fd[i] = 0; m_ov[i] = 0;
      end
    end else begin
      mcyc++;
      for (int i = 0; i < 2; i++) begin
        bit chg;
        chg = (din != m_q[i]);
        m_q[i] = din;
        m_fd[i] = 0;
        m_ov[i] = 0;
        if (m_act[i] && (mcyc - m_start[i]) == CHAR_T * m_len[i]) begin
          m_fd[i] = 1;
          if (chg || m_pend[i]) begin
            m_msg[i] = chg ? din : m_pval[i];
            m_start[i] = mcyc;
          end else begin
            m_act[i] = 0;
          end
          m_pend[i] = 0;
        end else if (m_act[i] && chg) begin
          m_ov[i] = m_pend[i];
          m_pend[i] = 1;
          m_pval[i] = din;
        end else if (chg) begin
          m_act[i] = 1;
          m_start[i] = mcyc;
          m_msg[i] = din;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("outputs_nl", {28'h0, outs(0)}, {28'h0, exp_tx(0), m_act[0], m_fd[0], m_ov[0]});
    chk("outputs_nn", {28'h0, outs(1)}, {28'h0, exp_tx(1), m_act[1], m_fd[1], m_ov[1]});
  end

  // ---------------- receiver / event monitor ----------------
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];
  bit         rx_on [2];
  int         rx_t [2];
  logic [7:0] rx_b [2];
  int         fd_cnt [2] = '{0, 0};
  int         ov_cnt [2] = '{0, 0};
  int         fd_cyc [2] = '{0, 0};
  int         fd_prev [2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [3:0] o;
      o = outs(i);
      if (o[1]) begin fd_cnt[i]++; fd_prev[i] = fd_cyc[i]; fd_cyc[i] = cyc; end
      if (o[0]) ov_cnt[i]++;
      if (reset) begin
        rx_on[i] = 0;
      end else if (!rx_on[i]) begin
        if (line(i) == 1'b0) begin rx_on[i] = 1; rx_t[i] = 0; end
      end else begin
        rx_t[i]++;
        if (rx_t[i] >= 24 && rx_t[i] <= 136 && ((rx_t[i] - 8) % DIV) == 0)
          rx_b[i][(rx_t[i] - 24) / DIV] = line(i);
        if (rx_t[i] == 152) begin
          chk("rx_stop_bit", {31'h0, line(i)}, 32'h1);
          if (i == 0) rxq0.push_back(rx_b[i]); else rxq1.push_back(rx_b[i]);
          rx_on[i] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int chg_edge = 0;

  task automatic set_din(input logic [7:0] v);
    @(negedge clk);
    din = v;
    chg_edge = cyc + 1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((bus_nl.busy || bus_nn.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, n, (n < 5000) ? n : 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input string exp);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < exp.len(); k++) begin
        logic [7:0] c;
        logic [7:0] got;
        c = exp.getc(k);
        if (i == 1 && (c == 8'h0D || c == 8'h0A)) continue;
        if (i == 0 ? rxq0.size() == 0 : rxq1.size() == 0) begin
          chk({name, "_rx_missing"}, 32'hFFFF_FFFF, {24'h0, c});
        end else begin
          got = (i == 0) ? rxq0.pop_front() : rxq1.pop_front();
          chk({name, (i == 0) ? "_rx_nl" : "_rx_nn"}, {24'h0, got}, {24'h0, c});
        end
      end
      chk({name, "_rx_extra"}, (i == 0) ? rxq0.size() : rxq1.size(), 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ov0 [2];
    int fc0 [2];
    reset = 1'b1;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset with 0x00 held.
    repeat (500) @(negedge clk);
    chk("t1_tx", {30'h0, bus_nl.tx, bus_nn.tx}, 32'h3);
    chk("t1_busy", {30'h0, bus_nl.busy, bus_nn.busy}, 32'h0);
    chk("t1_frame_done_cnt", fd_cnt[0] + fd_cnt[1], 0);
    chk("t1_overrun_cnt", ov_cnt[0] + ov_cnt[1], 0);

    // Single message 0x3C.
    set_din(8'h3C);
    @(negedge clk);
    chk("t2_first_edge_tx", {30'h0, bus_nl.tx, bus_nn.tx}, 32'h0);
    chk("t2_first_edge_busy", {30'h0, bus_nl.busy, bus_nn.busy}, 32'h3);
    wait_idle("t2");
    chk("t2_fd_latency_nl", fd_cyc[0] - chg_edge, 640);
    chk("t2_fd_latency_nn", fd_cyc[1] - chg_edge, 320);
    check_rx("t2", "3C\r\n");

    // Back-to-back via pending register.
    ov0 = ov_cnt;
    set_din(8'h01);
    repeat (60) @(negedge clk);
    set_din(8'h02);
    wait_idle("t3");
    chk("t3_fd_gap_nl", fd_cyc[0] - fd_prev[0], 640);
    chk("t3_fd_gap_nn", fd_cyc[1] - fd_prev[1], 320);
    chk("t3_overrun_nl", ov_cnt[0] - ov0[0], 0);
    chk("t3_overrun_nn", ov_cnt[1] - ov0[1], 0);
    check_rx("t3", "01\r\n02\r\n");

    // Overrun: 0x06 replaced by 0x07 before it is sent.
    ov0 = ov_cnt;
    set_din(8'h05);
    repeat (50) @(negedge clk);
    set_din(8'h06);
    repeat (50) @(negedge clk);
    set_din(8'h07);
    wait_idle("t4");
    chk("t4_overrun_nl", ov_cnt[0] - ov0[0], 1);
    chk("t4_overrun_nn", ov_cnt[1] - ov0[1], 1);
    check_rx("t4", "05\r\n07\r\n");

    // Asynchronous reset in the middle of char 1's data bits.
    set_din(8'h5A);
    repeat (200) @(negedge clk);
    fc0 = fd_cnt;
    @(negedge clk);
    din = 8'h00;
    #2 reset = 1'b1;
    #1;
    chk("t5_async_tx", {30'h0, bus_nl.tx, bus_nn.tx}, 32'h3);
    chk("t5_async_busy", {30'h0, bus_nl.busy, bus_nn.busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("t5_quiet_busy", {30'h0, bus_nl.busy, bus_nn.busy}, 32'h0);
    chk("t5_quiet_fd_nl", fd_cnt[0] - fc0[0], 0);
    chk("t5_quiet_fd_nn", fd_cnt[1] - fc0[1], 0);
    check_rx("t5a", "5");
    set_din(8'h12);
    wait_idle("t5b");
    check_rx("t5b", "12\r\n");

    // 0xFF -> 0x00 wrap.
    set_din(8'hFF);
    wait_idle("t6a");
    chk("t6a_fd_latency_nl", fd_cyc[0] - chg_edge, 640);
    chk("t6a_fd_latency_nn", fd_cyc[1] - chg_edge, 320);
    set_din(8'h00);
    wait_idle("t6b");
    chk("t6b_fd_latency_nl", fd_cyc[0] - chg_edge, 640);
    chk("t6b_fd_latency_nn", fd_cyc[1] - chg_edge, 320);
    check_rx("t6", "FF\r\n00\r\n");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
